mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Successor to the single-cycle combinational multiplier feeding HI/LO in the MIPS datapath.
- Sits beside the ALU; datapath control issues ops via start/busy/done handshake; mfhi/mflo read hi/lo outputs directly.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle, signed and unsigned.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_negate.sv | 12 +
 rtl/mdu_iter.sv | 185 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit (mdu_iter).
package mdu_pkg;

  localparam logic [2:0] MDU_MULTU = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // MULT and DIV treat operands as two's complement.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate: y = en ? -x : x.
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = en_i ? (~x_i + WIDTH'(1)) : x_i;

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider (ops DIVU/DIV).
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int W2    = 2 * WIDTH;

  // Handshake: start is sampled only in IDLE; busy is high in RUN/FIX; done
  // pulses for one cycle with hi/lo already updated; a new start is legal then.
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_res_q, neg_res_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg, accept_arith;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_step, acc_iter, prod_fix;

  assign a_neg = op_is_signed(op) & a[WIDTH-1];
  assign b_neg = op_is_signed(op) & b[WIDTH-1];

  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (.en_i(a_neg), .x_i(a), .y_o(a_mag));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (.en_i(b_neg), .x_i(b), .y_o(b_mag));
  mdu_negate #(.WIDTH(W2))    u_neg_p (.en_i(neg_res_q), .x_i(acc_q), .y_o(prod_fix));

  // acc = {partial product, multiplier}; add multiplicand on the LSB, then shift right.
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub, quo_fix, rem_fix;
  logic             div_borrow;
  logic [W2-1:0]    div_step;

  assign accept_arith = (op == MDU_MULTU) || (op == MDU_MULT) ||
                        (op == MDU_DIVU)  || (op == MDU_DIV);

  // acc = {remainder, dividend/quotient}; the next dividend bit enters the remainder.
  assign div_shift  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_borrow = div_shift < {1'b0, opnd_q};
  assign div_sub    = div_shift[WIDTH-1:0] - opnd_q;
  assign div_step   = {(div_borrow ? div_shift[WIDTH-1:0] : div_sub),
                       acc_q[WIDTH-2:0], ~div_borrow};
  assign acc_iter   = is_div_q ? div_step : mul_step;

  mdu_negate #(.WIDTH(WIDTH)) u_neg_q (.en_i(neg_res_q), .x_i(acc_q[WIDTH-1:0]),
                                       .y_o(quo_fix));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_r (.en_i(neg_rem_q), .x_i(acc_q[W2-1:WIDTH]),
                                       .y_o(rem_fix));
  assign div0 = div0_q;
`else
  assign accept_arith = (op == MDU_MULTU) || (op == MDU_MULT);
  assign acc_iter     = mul_step;
  assign div0         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    div0_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (accept_arith) begin
            state_d   = S_RUN;
            cnt_d     = CNT_W'(WIDTH);
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            opnd_d    = b_mag;
            neg_res_d = a_neg ^ b_neg;
`ifdef MDU_DIV_EN
            is_div_d  = op[1];
            neg_rem_d = a_neg;
`endif
          end else if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_iter;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            hi_d   = rem_fix;
            lo_d   = quo_fix;
            div0_d = (opnd_q == '0);
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
`else
          {hi_d, lo_d} = prod_fix;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
`endif
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: multiply, HI/LO moves, flush, reset and (with MDU_DIV_EN) divide.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div0;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc, bcyc, ndone;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count cycles from the current post-edge sample until done, bounded.
  task automatic wait_done(output int c, output int bc);
    c = 0; bc = 0;
    while (done !== 1'b1 && c < 200) begin
      if (busy === 1'b1) bc++;
      step();
      c++;
    end
  endtask

  task automatic count_done(input int n, output int nd);
    nd = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done === 1'b1) nd++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) step();
    chk("rst_hilo",  {hi, lo}, 64'h0);
    chk("rst_busy",  busy, 64'h0);
    chk("rst_done",  done, 64'h0);
    chk("rst_div0",  div0, 64'h0);
    chk("rst_state", dbg_state, 64'(S_IDLE));
    rst = 1'b1;
    step();

    // MTHI then MTLO on consecutive cycles
    op = MDU_MTHI; a = 32'h1234; start = 1'b1;
    step();
    chk("mthi_hi",   hi, 64'h1234);
    chk("mthi_busy", busy, 64'h0);
    chk("mthi_done", done, 64'h0);
    op = MDU_MTLO; a = 32'h5678;
    step();
    start = 1'b0;
    chk("mtlo_hilo", {hi, lo}, 64'h00001234_00005678);
    chk("mtlo_busy", busy, 64'h0);
    chk("mtlo_done", done, 64'h0);

    // MULTU max * max: latency and busy length
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_busy",  busy, 64'h1);
    chk("multu_state", dbg_state, 64'(S_RUN));
    chk("multu_stale", {hi, lo}, 64'h00001234_00005678);
    wait_done(cyc, bcyc);
    chk("multu_lat",   cyc, 64'd33);
    chk("multu_bcyc",  bcyc, 64'd33);
    chk("multu_res",   {hi, lo}, 64'hFFFFFFFE_00000001);
    chk("multu_div0",  div0, 64'h0);
    chk("multu_idle",  busy, 64'h0);

    // Back-to-back MULT issued in the done cycle; stray start mid-RUN ignored
    issue(MDU_MULT, 32'hFFFFFFF9, 32'd6);
    chk("b2b_busy", busy, 64'h1);
    chk("b2b_done", done, 64'h0);
    repeat (5) step();
    op = MDU_MULTU; a = 32'd1; b = 32'd1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc, bcyc);
    chk("mult_lat", cyc, 64'd27);
    chk("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);
    step();
    chk("mult_done_pulse", done, 64'h0);

    issue(MDU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc, bcyc);
    chk("mult_m1m1", {hi, lo}, 64'h00000000_00000001);
    issue(MDU_MULT, 32'h80000000, 32'h80000000);
    wait_done(cyc, bcyc);
    chk("mult_minmin", {hi, lo}, 64'h40000000_00000000);
    issue(MDU_MULTU, 32'h80000000, 32'd2);
    wait_done(cyc, bcyc);
    chk("multu_carry", {hi, lo}, 64'h00000001_00000000);

    // Flush mid-RUN: no done, hi/lo untouched
    issue(MDU_MULTU, 32'd3, 32'd5);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy",  busy, 64'h0);
    chk("flush_state", dbg_state, 64'(S_IDLE));
    count_done(40, ndone);
    chk("flush_ndone", ndone, 64'd0);
    chk("flush_hilo",  {hi, lo}, 64'h00000001_00000000);

    // flush beats start in IDLE; op 11x ignored
    op = MDU_MTHI; a = 32'hAAAA; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_hi", hi, 64'h1);
    op = 3'b110; a = 32'h5555; b = 32'h7; start = 1'b1;
    step();
    start = 1'b0;
    chk("nop_busy", busy, 64'h0);
    count_done(3, ndone);
    chk("nop_ndone", ndone, 64'd0);
    chk("nop_hilo", {hi, lo}, 64'h00000001_00000000);

`ifdef MDU_DIV_EN
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc, bcyc);
    chk("div_lat",  cyc, 64'd33);
    chk("div_res",  {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    chk("div_div0", div0, 64'h0);
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc, bcyc);
    chk("div_minm1", {hi, lo}, 64'h00000000_80000000);
    issue(MDU_DIVU, 32'd100, 32'd0);
    wait_done(cyc, bcyc);
    chk("divu0_res",  {hi, lo}, 64'h00000064_FFFFFFFF);
    chk("divu0_div0", div0, 64'h1);
    step();
    chk("divu0_div0_pulse", div0, 64'h0);
    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_done(cyc, bcyc);
    chk("divu_res", {hi, lo}, 64'h00000002_0000000E);
`else
    issue(MDU_DIVU, 32'd100, 32'd7);
    chk("nodiv_busy", busy, 64'h0);
    count_done(40, ndone);
    chk("nodiv_ndone", ndone, 64'd0);
    chk("nodiv_hilo", {hi, lo}, 64'h00000001_00000000);
    chk("nodiv_div0", div0, 64'h0);
`endif

    // Reset mid-op clears hi/lo immediately
    issue(MDU_MULTU, 32'd3, 32'd5);
    repeat (9) step();
    rst = 1'b0;
    #1;
    chk("rstmid_hilo",  {hi, lo}, 64'h0);
    chk("rstmid_busy",  busy, 64'h0);
    chk("rstmid_state", dbg_state, 64'(S_IDLE));
    step();
    rst = 1'b1;
    step();
    issue(MDU_MULTU, 32'd3, 32'd5);
    wait_done(cyc, bcyc);
    chk("post_rst_lat", cyc, 64'd33);
    chk("post_rst_res", {hi, lo}, 64'h00000000_0000000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
